// File: rtl/wb_arb_pkg.sv
// Shared types and defaults for the write-back port arbiter.
// Optional starve guard enabled by defining WB_STARVE_GUARD_EN.
package wb_arb_pkg;
  localparam int DEF_DEPTH        = 2;
  localparam int DEF_STARVE_LIMIT = 4;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } luEntry_t;
endpackage

// File: rtl/wb_result_fifo.sv
// Small in-order FIFO for long-latency results. It also exports the OR of the
// one-hot destination registers of all occupied slots.
module wb_result_fifo
  import wb_arb_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  luEntry_t      pushEntry,
  input  logic          pop,
  output luEntry_t      head,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty,
  output logic [31:0]   rdMask
);
  luEntry_t            mem [DEPTH];
  logic [DEPTH-1:0]    slotValid, slotValidNext;
  logic [AW-1:0]       wrPtr, rdPtr;
  logic                doPush, doPop;

  assign full   = (count == (AW+1)'(DEPTH));
  assign empty  = (count == '0);
  assign doPop  = pop & ~empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign doPush = push & (~full | doPop);
  assign head   = mem[rdPtr];

  always_comb begin
    slotValidNext = slotValid;
    if (doPop)  slotValidNext[rdPtr] = 1'b0;
    if (doPush) slotValidNext[wrPtr] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      count     <= '0;
      slotValid <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + AW'(1);
      if (doPop)  rdPtr <= rdPtr + AW'(1);
      count     <= count + (AW+1)'(doPush) - (AW+1)'(doPop);
      slotValid <= slotValidNext;
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= pushEntry;
  end

  // Built only from state, so it changes the cycle after a push or pop.
  always_comb begin
    rdMask = '0;
    for (int i = 0; i < DEPTH; i++)
      if (slotValid[i]) rdMask[mem[i].rd] = 1'b1;
  end
endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the W stage and a long-latency
// result source. Define WB_STARVE_GUARD_EN for the forced-drain starve guard.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int DEPTH        = DEF_DEPTH,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteW,
  input  logic [4:0]  WriteRegW,
  input  logic [31:0] ResultW,
  input  logic        lu_valid,
  input  logic [4:0]  lu_rd,
  input  logic [31:0] lu_data,
  output logic        lu_ready,
  output logic        rf_we,
  output logic [4:0]  rf_wa,
  output logic [31:0] rf_wd,
  output logic        wb_stall,
  output logic [31:0] pending_mask
);
  localparam int AW = $clog2(DEPTH);

  luEntry_t    head, pushEntry;
  logic [AW:0] count;
  logic        full, empty;
  logic        pipeReq, effPipe, stall, doPop, doPush, luLive, bypass;

  // Outputs must drop to reset values while rst is high, even mid-cycle.
  assign pipeReq = RegWriteW & (WriteRegW != 5'd0) & ~rst;

`ifdef WB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] starveCnt;

  // Fires on the STARVE_LIMIT-th consecutive cycle the pipeline would win.
  assign stall = ~empty & pipeReq & (starveCnt == SW'(STARVE_LIMIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                starveCnt <= '0;
    else if (doPop | empty) starveCnt <= '0;
    else if (effPipe)       starveCnt <= starveCnt + SW'(1);
  end
`else
  assign stall = 1'b0;
`endif

  assign effPipe  = pipeReq & ~stall;
  assign doPop    = ~empty & (stall | ~effPipe);
  assign lu_ready = (count < (AW+1)'(DEPTH)) | doPop;
  assign luLive   = lu_valid & lu_ready & ~rst & (lu_rd != 5'd0);
  assign bypass   = luLive & ~effPipe & empty;
  assign doPush   = luLive & ~bypass & (~full | doPop);

  assign pushEntry.rd   = lu_rd;
  assign pushEntry.data = lu_data;

  always_comb begin
    rf_we = 1'b0;
    rf_wa = '0;
    rf_wd = '0;
    if (doPop) begin
      rf_we = 1'b1;
      rf_wa = head.rd;
      rf_wd = head.data;
    end else if (effPipe) begin
      rf_we = 1'b1;
      rf_wa = WriteRegW;
      rf_wd = ResultW;
    end else if (bypass) begin
      rf_we = 1'b1;
      rf_wa = lu_rd;
      rf_wd = lu_data;
    end
  end

  assign wb_stall = stall;

  wb_result_fifo #(.DEPTH(DEPTH)) uFifo (
    .clk       (clk),
    .rst       (rst),
    .push      (doPush),
    .pushEntry (pushEntry),
    .pop       (doPop),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .rdMask    (pending_mask)
  );
endmodule
